bounce_controller: RTL and testbench

- Game-rule stage that sits between the paddle logic and the two `trajectory` instances (x axis and y axis).
- Consumes each instance's `coordinate` output and drives each instance's `direction` input, plus a shared `active` enable.
- Detects wall bounces, paddle hits and misses; keeps the score; sequences serve delay and game over.

---
 rtl/bounce_controller_pkg.sv | 23 ++
 rtl/bounce_controller_if.sv | 40 ++++
 rtl/bounce_controller_serve_timer.sv | 48 ++++
 rtl/bounce_controller.sv | 211 +++++++++++++++++++++
 tb/tb_bounce_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bounce_controller_pkg.sv
// Shared types and constants for the pong game-rule stage.
//   state_t  : top-level game sequencing states
//   coord_w  : coordinate width helper (WIDTH is the coordinate MSB index)
//   DIR_UP / DIR_DOWN : direction encodings (1 = increasing coordinate)
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Coordinates are WIDTH+1 bits wide, matching trajectory #(WIDTH).
  function automatic int coord_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/bounce_controller_if.sv
// Bundle of game signals between the bounce controller and its surroundings
// (paddle logic, the two trajectory instances, score display).
//   slave  : the bounce controller (consumes coordinates/paddles/start,
//            drives direction, enable, pulses, scores)
//   master : the environment feeding and observing the controller
interface bounce_controller_if #(
  parameter int WIDTH       = 8,
  parameter int SCORE_WIDTH = 4
) ();

  localparam int COORD_W = pong_pkg::coord_w(WIDTH);

  logic                   start;
  logic [COORD_W-1:0]     x_coord;
  logic [COORD_W-1:0]     y_coord;
  logic [COORD_W-1:0]     paddle_left;
  logic [COORD_W-1:0]     paddle_right;
  logic                   active;
  logic                   x_direction;
  logic                   y_direction;
  logic                   hit;
  logic                   point_left;
  logic                   point_right;
  logic [SCORE_WIDTH-1:0] score_left;
  logic [SCORE_WIDTH-1:0] score_right;
  logic                   game_over;

  modport slave (
    input  start, x_coord, y_coord, paddle_left, paddle_right,
    output active, x_direction, y_direction, hit, point_left, point_right,
           score_left, score_right, game_over
  );

  modport master (
    output start, x_coord, y_coord, paddle_left, paddle_right,
    input  active, x_direction, y_direction, hit, point_left, point_right,
           score_left, score_right, game_over
  );

endinterface

// File: rtl/bounce_controller_serve_timer.sv
// Serve delay timer: a loadable down-counter that parks at zero.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   load  : reload the counter with SERVE_DELAY-1
//   done  : registered flag, high while the counter holds zero
module serve_timer #(
  parameter int SERVE_DELAY = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(SERVE_DELAY) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SERVE_DELAY - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             done_r;

  // Next count: reload, decrement, or hold at zero.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = LOAD_VAL;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
  end

  // Counter and done flag; done is registered from the next count so it
  // always mirrors count_r == 0 without a combinational output path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
      done_r  <= 1'b1;
    end else begin
      count_r <= count_next_s;
      done_r  <= (count_next_s == {CNT_W{1'b0}});
    end
  end

  assign done = done_r;

endmodule

// File: rtl/bounce_controller.sv
// Pong game-rule stage between the paddle logic and the x/y trajectories.
// Watches the ball coordinates, flips the trajectory directions on wall
// bounces and paddle returns, scores misses, and sequences serve delay and
// game over.
//   clock, reset : system clock (rising edge), asynchronous active-high reset
//   bus (slave)  : start, x_coord, y_coord, paddle_left, paddle_right in;
//                  active, x_direction, y_direction, hit, point_left,
//                  point_right, score_left, score_right, game_over out
// All outputs are registered; each responds one cycle after the sampled
// coordinates.
module bounce_controller
  import pong_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int X_MAX         = 400,
  parameter int Y_MAX         = 300,
  parameter int PADDLE_HEIGHT = 40,
  parameter int SERVE_DELAY   = 16,
  parameter int WIN_SCORE     = 7,
  parameter int SCORE_WIDTH   = 4
) (
  input logic                clock,
  input logic                reset,
  bounce_controller_if.slave bus
);

  localparam int COORD_W = coord_w(WIDTH);
  localparam logic [COORD_W-1:0]     X_LIM   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0]     Y_LIM   = COORD_W'(Y_MAX);
  localparam logic [COORD_W:0]       PH_EXT  = (COORD_W + 1)'(PADDLE_HEIGHT);
  localparam logic [SCORE_WIDTH-1:0] WIN_VAL = SCORE_WIDTH'(WIN_SCORE);

  // Paddle covers y when top <= y < top + height; the sum carries one
  // extra bit so a paddle near the bottom of the range cannot wrap.
  function automatic logic paddle_covers(input logic [COORD_W-1:0] top,
                                         input logic [COORD_W-1:0] y);
    logic [COORD_W:0] bottom;
    bottom = {1'b0, top} + PH_EXT;
    return (top <= y) && ({1'b0, y} < bottom);
  endfunction

  // Score increment that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] s);
    return (s == {SCORE_WIDTH{1'b1}}) ? s : s + {{(SCORE_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t                 state_r;
  logic                   active_r;
  logic                   x_dir_r;
  logic                   y_dir_r;
  logic                   hit_r;
  logic                   point_left_r;
  logic                   point_right_r;
  logic [SCORE_WIDTH-1:0] score_left_r;
  logic [SCORE_WIDTH-1:0] score_right_r;
  logic                   game_over_r;
  logic                   miss_right_r;

  logic load_s;
  logic timer_done_s;
  logic y_bottom_s;
  logic y_top_s;
  logic right_edge_s;
  logic left_edge_s;
  logic right_cover_s;
  logic left_cover_s;
  logic win_s;

  // Edge and coverage decodes. Wall flips only fire when moving toward the
  // wall, so a coordinate held at the wall cannot make the direction toggle.
  always_comb begin
    y_bottom_s    = (bus.y_coord >= Y_LIM) && (y_dir_r == DIR_UP);
    y_top_s       = (bus.y_coord == {COORD_W{1'b0}}) && (y_dir_r == DIR_DOWN);
    right_edge_s  = (bus.x_coord >= X_LIM) && (x_dir_r == DIR_UP);
    left_edge_s   = (bus.x_coord == {COORD_W{1'b0}}) && (x_dir_r == DIR_DOWN);
    right_cover_s = paddle_covers(bus.paddle_right, bus.y_coord);
    left_cover_s  = paddle_covers(bus.paddle_left, bus.y_coord);
    win_s         = (score_left_r == WIN_VAL) || (score_right_r == WIN_VAL);
  end

  // Serve timer reload: on a new game and after a point that does not end
  // the game, aligned with the transition into SERVE.
  always_comb begin
    load_s = 1'b0;
    case (state_r)
      IDLE:      load_s = bus.start;
      POINT:     load_s = ~win_s;
      GAME_OVER: load_s = bus.start;
      default:   load_s = 1'b0;
    endcase
  end

  serve_timer #(
    .SERVE_DELAY (SERVE_DELAY)
  ) u_serve_timer (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .done  (timer_done_s)
  );

  // Game sequencing FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      active_r      <= 1'b0;
      x_dir_r       <= DIR_UP;
      y_dir_r       <= DIR_UP;
      hit_r         <= 1'b0;
      point_left_r  <= 1'b0;
      point_right_r <= 1'b0;
      score_left_r  <= {SCORE_WIDTH{1'b0}};
      score_right_r <= {SCORE_WIDTH{1'b0}};
      game_over_r   <= 1'b0;
      miss_right_r  <= 1'b0;
    end else begin
      hit_r         <= 1'b0;
      point_left_r  <= 1'b0;
      point_right_r <= 1'b0;
      case (state_r)
        IDLE: begin
          active_r <= 1'b0;
          if (bus.start) begin
            state_r <= SERVE;
          end
        end

        SERVE: begin
          if (timer_done_s) begin
            state_r  <= PLAY;
            active_r <= 1'b1;
          end else begin
            active_r <= 1'b0;
          end
        end

        PLAY: begin
          // The y flip is independent of, and combined with, any x event.
          if (y_bottom_s) begin
            y_dir_r <= DIR_DOWN;
          end else if (y_top_s) begin
            y_dir_r <= DIR_UP;
          end

          if (right_edge_s) begin
            if (right_cover_s) begin
              x_dir_r <= DIR_DOWN;
              hit_r   <= 1'b1;
            end else begin
              score_left_r <= sat_inc(score_left_r);
              point_left_r <= 1'b1;
              active_r     <= 1'b0;
              miss_right_r <= 1'b1;
              state_r      <= POINT;
            end
          end else if (left_edge_s) begin
            if (left_cover_s) begin
              x_dir_r <= DIR_UP;
              hit_r   <= 1'b1;
            end else begin
              score_right_r <= sat_inc(score_right_r);
              point_right_r <= 1'b1;
              active_r      <= 1'b0;
              miss_right_r  <= 1'b0;
              state_r       <= POINT;
            end
          end
        end

        POINT: begin
          active_r <= 1'b0;
          // Next serve heads away from the edge that was missed.
          x_dir_r  <= miss_right_r ? DIR_DOWN : DIR_UP;
          if (win_s) begin
            state_r     <= GAME_OVER;
            game_over_r <= 1'b1;
          end else begin
            state_r <= SERVE;
          end
        end

        GAME_OVER: begin
          active_r <= 1'b0;
          if (bus.start) begin
            score_left_r  <= {SCORE_WIDTH{1'b0}};
            score_right_r <= {SCORE_WIDTH{1'b0}};
            game_over_r   <= 1'b0;
            state_r       <= SERVE;
          end
        end

        default: begin
          state_r     <= IDLE;
          active_r    <= 1'b0;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.active      = active_r;
  assign bus.x_direction = x_dir_r;
  assign bus.y_direction = y_dir_r;
  assign bus.hit         = hit_r;
  assign bus.point_left  = point_left_r;
  assign bus.point_right = point_right_r;
  assign bus.score_left  = score_left_r;
  assign bus.score_right = score_right_r;
  assign bus.game_over   = game_over_r;

endmodule

// File: tb/tb_bounce_controller.sv
// Self-checking bench for bounce_controller: directed game scenarios plus
// randomized edge events. Each edge event pushes its expected pulse into a
// scoreboard queue; a negedge monitor pops and compares whenever a pulse
// appears.
module tb_bounce_controller;

  localparam int WIDTH   = 8;
  localparam int COORD_W = WIDTH + 1;
  localparam int X_MAX   = 400;
  localparam int Y_MAX   = 300;
  localparam int PH      = 40;
  localparam int SD      = 16;
  localparam int WIN     = 7;
  localparam int SW      = 4;
  localparam int SMAX    = (1 << SW) - 1;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  bounce_controller_if #(.WIDTH(WIDTH), .SCORE_WIDTH(SW)) bus ();

  bounce_controller #(
    .WIDTH(WIDTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .PADDLE_HEIGHT(PH),
    .SERVE_DELAY(SD), .WIN_SCORE(WIN), .SCORE_WIDTH(SW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // kind: 1 = hit, 2 = point_left, 4 = point_right
  typedef struct {
    int kind;
    int xdir;
    int ydir;
    int sl;
    int sr;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference game state
  int m_sl, m_sr, m_xdir, m_ydir;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && (bus.hit === 1'b1 || bus.point_left === 1'b1 || bus.point_right === 1'b1)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got hit=%0d point_left=%0d point_right=%0d expected no pulse at %0t",
                   bus.hit, bus.point_left, bus.point_right, $time);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", int'({bus.point_right, bus.point_left, bus.hit}), e.kind);
          chk("pulse_x_direction", int'(bus.x_direction), e.xdir);
          chk("pulse_y_direction", int'(bus.y_direction), e.ydir);
          chk("pulse_score_left", int'(bus.score_left), e.sl);
          chk("pulse_score_right", int'(bus.score_right), e.sr);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic start_game();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges until active rises; should be exactly the serve delay.
  task automatic wait_active(input string name);
    int n;
    n = 0;
    while (bus.active !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(name, n, SD);
  endtask

  // One ball arrival at whichever x edge the ball is heading to.
  task automatic edge_event(input int yv, input int pad, input int xx);
    int   right;
    int   cov;
    exp_t e;
    right = m_xdir;
    cov   = (pad <= yv) && (yv < pad + PH);
    if (yv >= Y_MAX && m_ydir == 1) m_ydir = 0;
    else if (yv == 0 && m_ydir == 0) m_ydir = 1;
    if (cov != 0) begin
      m_xdir = 1 - m_xdir;
      e.kind = 1;
    end else if (right != 0) begin
      m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX;
      e.kind = 2;
    end else begin
      m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX;
      e.kind = 4;
    end
    e.xdir = m_xdir;
    e.ydir = m_ydir;
    e.sl   = m_sl;
    e.sr   = m_sr;
    sb.push_back(e);

    bus.x_coord = (right != 0) ? COORD_W'(X_MAX + xx) : '0;
    bus.y_coord = COORD_W'(yv);
    if (right != 0) bus.paddle_right = COORD_W'(pad);
    else            bus.paddle_left  = COORD_W'(pad);
    tick();
    bus.x_coord = COORD_W'(200);
    bus.y_coord = COORD_W'(150);

    if (cov == 0) begin
      chk("miss_active_low", int'(bus.active), 0);
      tick();
      m_xdir = (right != 0) ? 0 : 1;
      chk("point_x_direction", int'(bus.x_direction), m_xdir);
      chk("point_y_direction", int'(bus.y_direction), m_ydir);
      if (m_sl == WIN || m_sr == WIN) begin
        chk("game_over_set", int'(bus.game_over), 1);
        repeat (20) tick();
        chk("game_over_hold", int'(bus.game_over), 1);
        chk("game_over_inactive", int'(bus.active), 0);
        chk("game_over_score_left", int'(bus.score_left), m_sl);
        chk("game_over_score_right", int'(bus.score_right), m_sr);
        start_game();
        m_sl = 0;
        m_sr = 0;
        chk("restart_game_over", int'(bus.game_over), 0);
        chk("restart_score_left", int'(bus.score_left), 0);
        chk("restart_score_right", int'(bus.score_right), 0);
      end else begin
        chk("point_no_game_over", int'(bus.game_over), 0);
      end
      wait_active("serve_delay_after_point");
    end
  endtask

  initial begin : stimulus
    int yv, pad, xx;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.x_coord      = COORD_W'(200);
    bus.y_coord      = COORD_W'(150);
    bus.paddle_left  = '0;
    bus.paddle_right = '0;
    m_sl = 0; m_sr = 0; m_xdir = 1; m_ydir = 1;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("reset_active", int'(bus.active), 0);
    chk("reset_x_direction", int'(bus.x_direction), 1);
    chk("reset_y_direction", int'(bus.y_direction), 1);
    chk("reset_pulses", int'({bus.point_right, bus.point_left, bus.hit}), 0);
    chk("reset_score_left", int'(bus.score_left), 0);
    chk("reset_score_right", int'(bus.score_right), 0);
    chk("reset_game_over", int'(bus.game_over), 0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_active", int'(bus.active), 0);

    // First serve
    start_game();
    chk("serve_active_low", int'(bus.active), 0);
    wait_active("serve_delay_first");
    chk("play_x_direction", int'(bus.x_direction), 1);
    chk("play_y_direction", int'(bus.y_direction), 1);

    // Bottom wall bounce, held coordinate, top wall bounce
    bus.y_coord = COORD_W'(Y_MAX);
    tick();
    m_ydir = 0;
    chk("y_bottom_flip", int'(bus.y_direction), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("y_hold_no_flip", int'(bus.y_direction), 0);
    end
    bus.y_coord = '0;
    tick();
    m_ydir = 1;
    chk("y_top_flip", int'(bus.y_direction), 1);
    bus.y_coord = COORD_W'(150);

    // start is ignored during play
    start_game();
    tick();
    chk("start_ignored_play", int'(bus.active), 1);

    // Right paddle boundary cases, interleaved with left returns
    edge_event(120, 100, 0);
    edge_event(50, 30, 0);
    edge_event(120, 81, 0);
    edge_event(50, 30, 0);
    edge_event(120, 80, 0);
    // Left-edge miss
    edge_event(50, 200, 0);
    chk("after_left_miss_x_direction", int'(bus.x_direction), 1);

    // Right-edge misses until the game ends
    while (m_sl < WIN && bus.game_over === 1'b0 && checks < 5000) begin
      if (m_xdir == 1) edge_event(120, 400, 0);
      else             edge_event(50, 30, 0);
      if (m_sl == 0) break;
    end

    // Randomized play
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       yv = Y_MAX + int'($urandom_range(0, 20));
        1:       yv = 0;
        default: yv = int'($urandom_range(1, Y_MAX - 1));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        pad = yv - int'($urandom_range(0, 50));
        if (pad < 0) pad = 0;
      end else begin
        pad = int'($urandom_range(0, (1 << COORD_W) - 1));
      end
      xx = int'($urandom_range(0, 111));
      edge_event(yv, pad, xx);
    end

    // Reset between edges with a hit pulse in flight
    if (m_xdir == 1) begin
      bus.x_coord = COORD_W'(X_MAX); bus.y_coord = COORD_W'(120); bus.paddle_right = COORD_W'(100);
    end else begin
      bus.x_coord = '0; bus.y_coord = COORD_W'(50); bus.paddle_left = COORD_W'(30);
    end
    tick();
    #1 reset = 1'b1;
    #1;
    chk("midreset_active", int'(bus.active), 0);
    chk("midreset_x_direction", int'(bus.x_direction), 1);
    chk("midreset_y_direction", int'(bus.y_direction), 1);
    chk("midreset_pulses", int'({bus.point_right, bus.point_left, bus.hit}), 0);
    chk("midreset_score_left", int'(bus.score_left), 0);
    chk("midreset_score_right", int'(bus.score_right), 0);
    chk("midreset_game_over", int'(bus.game_over), 0);
    bus.x_coord = COORD_W'(200);
    bus.y_coord = COORD_W'(150);
    m_sl = 0; m_sr = 0; m_xdir = 1; m_ydir = 1;
    @(negedge clock);
    reset = 1'b0;
    tick();
    start_game();
    wait_active("serve_delay_after_reset");

    // Corner: right paddle hit and bottom wall in the same cycle
    edge_event(Y_MAX, 280, 0);
    chk("corner_x_direction", int'(bus.x_direction), 0);
    chk("corner_y_direction", int'(bus.y_direction), 0);

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
